// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, field positions and timer state type
package csr_pkg;

    localparam logic [13:0] CSR_TID   = 14'h40;
    localparam logic [13:0] CSR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_TICLR = 14'h44;

    localparam int TCFG_EN         = 0;
    localparam int TCFG_PERIODIC   = 1;
    localparam int TCFG_INITVAL_LO = 2;
    localparam int TCFG_INITVAL_HI = 31;

    localparam int TICLR_CLR = 0;
    localparam int ESTAT_TI  = 11;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } timer_state_e;

endpackage

// File: rtl/csr_timer_if.sv
// rtl/csr_timer_if.sv - CSR write/read bus shared by the CSR file and the timer unit
interface csr_timer_if;
    logic        csr_wr_en;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_rhit;

    modport master (
        output csr_wr_en, csr_waddr, csr_wdata, csr_raddr,
        input  csr_rdata, csr_rhit
    );

    modport slave (
        input  csr_wr_en, csr_waddr, csr_wdata, csr_raddr,
        output csr_rdata, csr_rhit
    );
endinterface

// File: rtl/csr_timer_stable_counter.sv
// rtl/csr_timer_stable_counter.sv - free-running 64-bit stable counter
module stable_counter (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] cnt_o
);
    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    assign cnt_d = cnt_q + 64'd1;
    assign cnt_o = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - TID/TCFG/TVAL/TICLR timer CSRs, timer interrupt and stable counter
module csr_timer
    import csr_pkg::*;
#(
    parameter logic [31:0] CORE_ID = 32'h0,
    parameter int          TIMER_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    csr_timer_if.slave      bus,
    output logic            timer_int,
    output logic [63:0]     cnt_value,
    output logic [31:0]     tid
);
    logic [31:0]        tid_q,   tid_d;
    logic [31:0]        tcfg_q,  tcfg_d;
    logic [TIMER_W-1:0] tval_q,  tval_d;
    timer_state_e       state_q, state_d;
    logic               ti_q,    ti_d;

    logic               wr_tid, wr_tcfg, wr_ticlr;
    logic               expire;
    logic [TIMER_W-1:0] wr_reload, cfg_reload;
    logic [31:0]        tval_rd;

    assign wr_tid   = bus.csr_wr_en && (bus.csr_waddr == CSR_TID);
    assign wr_tcfg  = bus.csr_wr_en && (bus.csr_waddr == CSR_TCFG);
    assign wr_ticlr = bus.csr_wr_en && (bus.csr_waddr == CSR_TICLR);

    assign expire     = (state_q == TMR_RUN) && (tval_q == '0);
    assign wr_reload  = {bus.csr_wdata[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
    assign cfg_reload = {tcfg_q[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};

    always_comb begin
        tid_d   = tid_q;
        tcfg_d  = tcfg_q;
        tval_d  = tval_q;
        state_d = state_q;
        ti_d    = ti_q;

        if (wr_tid) begin
            tid_d = bus.csr_wdata;
        end

        // A TCFG write overrides the countdown, including a coincident expiry.
        if (wr_tcfg) begin
            tcfg_d  = bus.csr_wdata;
            tval_d  = wr_reload;
            state_d = bus.csr_wdata[TCFG_EN] ? TMR_RUN : TMR_IDLE;
        end else if (state_q == TMR_RUN) begin
            if (expire) begin
                if (tcfg_q[TCFG_PERIODIC]) begin
                    tval_d = cfg_reload;
                end else begin
                    tval_d  = '1;
                    state_d = TMR_IDLE;
                end
            end else begin
                tval_d = tval_q - TIMER_W'(1);
            end
        end

        // Setting wins over clearing so an expiry is never lost.
        if (expire) begin
            ti_d = 1'b1;
        end else if (wr_ticlr && bus.csr_wdata[TICLR_CLR]) begin
            ti_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tid_q   <= CORE_ID;
            tcfg_q  <= '0;
            tval_q  <= '0;
            state_q <= TMR_IDLE;
            ti_q    <= 1'b0;
        end else begin
            tid_q   <= tid_d;
            tcfg_q  <= tcfg_d;
            tval_q  <= tval_d;
            state_q <= state_d;
            ti_q    <= ti_d;
        end
    end

    always_comb begin
        tval_rd                = '0;
        tval_rd[TIMER_W-1:0]   = tval_q;
    end

    always_comb begin
        bus.csr_rhit  = 1'b0;
        bus.csr_rdata = '0;
        case (bus.csr_raddr)
            CSR_TID: begin
                bus.csr_rhit  = 1'b1;
                bus.csr_rdata = tid_q;
            end
            CSR_TCFG: begin
                bus.csr_rhit  = 1'b1;
                bus.csr_rdata = tcfg_q;
            end
            CSR_TVAL: begin
                bus.csr_rhit  = 1'b1;
                bus.csr_rdata = tval_rd;
            end
            CSR_TICLR: begin
                bus.csr_rhit  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign timer_int = ti_q;
    assign tid       = tid_q;

    stable_counter u_stable_counter (
        .clk   (clk),
        .reset (reset),
        .cnt_o (cnt_value)
    );
endmodule
